// File: rtl/aesl_deadlock_report_ctrl_if.sv
// Record handshake between the deadlock sequencer and the co-simulation bench.
// The sequencer drives one status record per dataflow process; the bench answers with ready.
interface aesl_deadlock_report_ctrl_if #(
  parameter int NUM_PROC = 8,
  parameter int IDX_W    = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1
);
  logic             report_valid;
  logic             report_ready;
  logic [IDX_W-1:0] report_idx;
  logic [1:0]       report_code;
  logic             report_last;

  modport master (output report_valid, report_idx, report_code, report_last,
                  input  report_ready);
  modport slave  (input  report_valid, report_idx, report_code, report_last,
                  output report_ready);
endinterface

// File: rtl/aesl_deadlock_report_ctrl.sv
// Debounces the dataflow monitor's block flag, freezes a snapshot on confirmed deadlock,
// then streams one {blocked, idle} record per process and holds a sticky deadlock flag.
module aesl_deadlock_report_ctrl #(
  parameter int NUM_PROC    = 8,
  parameter int NUM_AXIS    = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  block_in,
  input  logic [2*NUM_AXIS-1:0] axis_block_info,
  input  logic [NUM_PROC-1:0]   inst_idle_sigs,
  input  logic [NUM_PROC-1:0]   inst_block_sigs,
  aesl_deadlock_report_ctrl_if.master rpt,
  output logic                  deadlock,
  output logic [2*NUM_AXIS-1:0] axis_snapshot,
  output logic [CNT_W-1:0]      detect_cycle
);
  localparam int IDX_W = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;

  typedef enum logic [2:0] {
    IDLE, ARMED, CONFIRM, SNAPSHOT, REPORT, HALTED
  } state_t;

  state_t                state_q;
  logic [CNT_W-1:0]      hold_q, hold_d;
  logic [CNT_W-1:0]      cyc_q, cyc_d;
  logic [IDX_W-1:0]      idx_q;
  logic                  valid_q;
  logic                  deadlock_q;
  logic [NUM_PROC-1:0]   idle_snap_q, blk_snap_q;
  logic [2*NUM_AXIS-1:0] axis_q;
  logic [CNT_W-1:0]      det_q;

  always_comb begin
    hold_d = hold_q + 1'b1;
    cyc_d  = (enable && (cyc_q != '1)) ? cyc_q + 1'b1 : cyc_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      cyc_q       <= '0;
      idx_q       <= '0;
      valid_q     <= 1'b0;
      deadlock_q  <= 1'b0;
      idle_snap_q <= '0;
      blk_snap_q  <= '0;
      axis_q      <= '0;
      det_q       <= '0;
    end else begin
      cyc_q <= cyc_d;
      // enable low outranks clear, which outranks handshake progress
      if (!enable) begin
        state_q    <= IDLE;
        hold_q     <= '0;
        idx_q      <= '0;
        valid_q    <= 1'b0;
        deadlock_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: state_q <= ARMED;
          ARMED: begin
            hold_q <= '0;
            if (block_in) begin
              hold_q  <= CNT_W'(1);
              state_q <= (HOLD_CYCLES == 1) ? SNAPSHOT : CONFIRM;
            end
          end
          CONFIRM: begin
            if (!block_in) begin
              hold_q  <= '0;
              state_q <= ARMED;
            end else begin
              hold_q <= hold_d;
              if (hold_d == CNT_W'(HOLD_CYCLES)) state_q <= SNAPSHOT;
            end
          end
          SNAPSHOT: begin
            idle_snap_q <= inst_idle_sigs;
            blk_snap_q  <= inst_block_sigs;
            axis_q      <= axis_block_info;
            det_q       <= cyc_q;
            deadlock_q  <= 1'b1;
            idx_q       <= '0;
            valid_q     <= 1'b1;
            hold_q      <= '0;
            state_q     <= REPORT;
          end
          REPORT: begin
            if (clear) begin
              valid_q    <= 1'b0;
              idx_q      <= '0;
              deadlock_q <= 1'b0;
              state_q    <= ARMED;
            end else if (rpt.report_ready) begin
              if (idx_q == IDX_W'(NUM_PROC - 1)) begin
                valid_q <= 1'b0;
                idx_q   <= '0;
                state_q <= HALTED;
              end else begin
                idx_q <= idx_q + 1'b1;
              end
            end
          end
          HALTED: begin
            if (clear) begin
              deadlock_q <= 1'b0;
              state_q    <= ARMED;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Codes come only from the frozen snapshot and read as zero outside a record.
  assign rpt.report_valid = valid_q;
  assign rpt.report_idx   = idx_q;
  assign rpt.report_code  = valid_q ? {blk_snap_q[idx_q], idle_snap_q[idx_q]} : 2'b00;
  assign rpt.report_last  = valid_q && (idx_q == IDX_W'(NUM_PROC - 1));
  assign deadlock         = deadlock_q;
  assign axis_snapshot    = axis_q;
  assign detect_cycle     = det_q;
endmodule

// File: doc/aesl_deadlock_report_ctrl.md
# aesl_deadlock_report_ctrl

Sequencer for the encoder dataflow deadlock monitor in the co-simulation harness. It debounces the monitor's `block` flag, confirms a deadlock only after it persists, and freezes a snapshot of per-process and AXIS state. It then streams one status record per dataflow process to the testbench over a valid/ready handshake and holds a sticky `deadlock` flag until the bench clears it.

## Interface

- `NUM_PROC`, 8, number of dataflow processes monitored.
- `NUM_AXIS`, 2, number of AXIS channels; the info bus is 2*NUM_AXIS bits.
- `HOLD_CYCLES`, 16, consecutive cycles `block_in` must be high to confirm; legal range 1..2^CNT_W-1.
- `CNT_W`, 16, width of the hold counter and the cycle timestamp.

- `clock` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: arms detection; low forces IDLE.
- `clear` in 1: one-cycle pulse; leaves HALTED or aborts REPORT.
- `block_in` in 1: monitor deadlock flag.
- `axis_block_info` in 2*NUM_AXIS: monitor AXIS info.
- `inst_idle_sigs` in NUM_PROC: per-process idle.
- `inst_block_sigs` in NUM_PROC: per-process channel-blocked.
- `report_ready` in 1: bench accepts a record.
- `report_valid` out 1: record present.
- `report_idx` out clog2(NUM_PROC): process index of the record.
- `report_code` out 2: 0 running, 1 idle, 2 channel-blocked, 3 idle and blocked.
- `report_last` out 1: high on the final record (idx NUM_PROC-1).
- `deadlock` out 1: sticky confirmed-deadlock flag.
- `axis_snapshot` out 2*NUM_AXIS: frozen `axis_block_info`.
- `detect_cycle` out CNT_W: cycle timestamp at confirmation.

## Operation

- States: IDLE, ARMED, CONFIRM, SNAPSHOT, REPORT, HALTED.
- IDLE: entered on reset or whenever `enable`=0 (highest priority after reset, any state). Goes to ARMED when `enable`=1.
- ARMED: hold counter = 0. If `block_in`=1, load hold counter = 1 and go to CONFIRM. If HOLD_CYCLES=1, go directly to SNAPSHOT.
- CONFIRM:
  - If `block_in`=0, return to ARMED and zero the counter.
  - Otherwise increment the counter. When it reaches HOLD_CYCLES, go to SNAPSHOT.
- SNAPSHOT, one cycle:
  - Capture `inst_idle_sigs`, `inst_block_sigs` and `axis_block_info` into internal registers and `axis_snapshot`.
  - Capture the cycle counter into `detect_cycle`.
  - Set `deadlock`=1 and the report index to 0, then go to REPORT.
- REPORT:
  - `report_valid`=1. `report_code` = {blocked[idx], idle[idx]} taken from the snapshot, never from live inputs.
  - The record transfers when valid & ready. The index then increments. The transfer at idx NUM_PROC-1 goes to HALTED.
  - `valid`, `idx` and `code` stay stable while `ready`=0.
- HALTED: `deadlock` stays 1 and inputs are ignored. `clear` goes to ARMED.
- `clear` in REPORT aborts the report and goes to ARMED. `clear` in any other state has no effect.
- `deadlock` falls only on reset, `enable`=0, or `clear` in REPORT/HALTED. `axis_snapshot` and `detect_cycle` hold their values until the next SNAPSHOT or reset.
- Cycle counter: free-running while `enable`=1, held while `enable`=0, saturates at all-ones (no wrap). Reset to 0.

## Timing

- Reset values: `report_valid`=0, `report_idx`=0, `report_code`=0, `report_last`=0, `deadlock`=0, `axis_snapshot`=0, `detect_cycle`=0. State = IDLE, counters = 0.
- All outputs are registered except `report_code` and `report_last`, which are decoded from registered state and index.
- Latency, with `block_in` first seen high at edge T (ARMED at T) and high for every edge T..T+HOLD_CYCLES-1:
  - SNAPSHOT is the state after edge T+HOLD_CYCLES-1.
  - `deadlock` and the first `report_valid` are visible after edge T+HOLD_CYCLES.
- Snapshot data are the inputs sampled on the SNAPSHOT cycle's edge.
- With `ready` tied to 1, the report takes exactly NUM_PROC cycles.
- Simultaneous events:
  - `enable`=0 beats `clear`, which beats handshake progress.
  - `clear` together with the last transfer goes to ARMED.
- Reset mid-REPORT: all outputs return to reset values on the next edge.

## Test plan

- HOLD_CYCLES=16; `block_in` high 15 cycles then low -> `deadlock` never rises; state returns to ARMED; counter=0.
- `block_in` held high from cycle 10; `inst_idle_sigs`=8'h0F, `inst_block_sigs`=8'h30, `axis_block_info`=4'hD -> `deadlock`=1 at cycle 26. Records, `ready`=1: codes idx0-3 = 1, idx4-5 = 2, idx6-7 = 0. `report_last` only on idx7. `axis_snapshot`=4'hD. `detect_cycle`=25.
- Same stimulus, `ready` toggling 1,0,0,1… -> idx/code stable while ready=0; exactly 8 transfers; inputs changed after SNAPSHOT do not alter codes.
- `clear` pulsed during the idx3 record -> `report_valid` drops next cycle; `deadlock`=0; ARMED. A new 16-cycle block run produces a full 8-record report starting at idx0.
- `enable` dropped in HALTED -> IDLE, all outputs except the snapshot registers cleared, cycle counter frozen; re-enable resumes counting from the frozen value.
- `reset` asserted mid-CONFIRM and mid-REPORT -> all outputs at reset values next cycle; no record emitted.
